// File: rtl/stage_seq_pkg.sv
// Shared types and helpers for the stage sequencer and its timeout counter.
package stage_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_POST,
    ST_ACK,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  function automatic int idx_width(input int nstage);
    return (nstage > 1) ? $clog2(nstage) : 1;
  endfunction

  // The err_stage bit that flags a REQ-phase timeout sits just above the stage index.
  function automatic int err_req_bit(input int nstage);
    return idx_width(nstage);
  endfunction

endpackage

// File: rtl/seq_timeout.sv
// Wait-phase watchdog: counts enabled cycles since the last clear and flags the TMO-th one.
module seq_timeout #(
  parameter int TMO = 1048576
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] LAST = (TMO > 0) ? CW'(TMO - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // TMO of zero disables the watchdog entirely.
  assign expired = (TMO > 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Run controller: walks the enabled stages through their req/res handshakes one at a
// time, then compares check_a against check_b and reports the pass.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int W      = 128,
  parameter int TMO    = 1048576,
  parameter int PCW    = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         loop_mode,
  input  logic                         err_clr,
  input  logic [NSTAGE-1:0]            stage_en,
  input  logic [NSTAGE-1:0]            req_ready,
  input  logic [NSTAGE-1:0]            req_busy,
  input  logic [NSTAGE-1:0]            res_valid,
  output logic [NSTAGE-1:0]            req_valid,
  output logic [NSTAGE-1:0]            res_ready,
  output logic [NSTAGE-1:0]            post_stb,
  input  logic [W-1:0]                 check_a,
  input  logic [W-1:0]                 check_b,
  output logic                         busy,
  output logic                         done,
  output logic                         succ,
  output logic                         err,
  output logic [idx_width(NSTAGE):0]   err_stage,
  output logic [idx_width(NSTAGE)-1:0] stage_idx,
  output logic [PCW-1:0]               pass_cnt
);

  localparam int SIW     = idx_width(NSTAGE);
  localparam int ERR_REQ = err_req_bit(NSTAGE);

  seq_state_e        state_q, state_d;
  logic [NSTAGE-1:0] stage_en_q, stage_en_d;
  logic [NSTAGE-1:0] req_valid_q, req_valid_d;
  logic [NSTAGE-1:0] res_ready_q, res_ready_d;
  logic [SIW-1:0]    stage_idx_q, stage_idx_d;
  logic [SIW:0]      err_stage_q, err_stage_d;
  logic [PCW-1:0]    pass_cnt_q, pass_cnt_d;
  logic              succ_q, succ_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic              first_found, first_q_found, next_found;
  logic [SIW-1:0]    first_idx, first_q_idx, next_idx;
  logic              tmo_clear, tmo_enable, tmo_expired;
  logic              unused_busy;

  assign unused_busy = ^req_busy;

  // Priority encoders: lowest enabled stage overall, and lowest enabled stage above the current one.
  always_comb begin
    first_found   = 1'b0;
    first_idx     = '0;
    first_q_found = 1'b0;
    first_q_idx   = '0;
    next_found    = 1'b0;
    next_idx      = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (stage_en[i]) begin
        first_found = 1'b1;
        first_idx   = SIW'(i);
      end
      if (stage_en_q[i]) begin
        first_q_found = 1'b1;
        first_q_idx   = SIW'(i);
      end
      if (stage_en_q[i] && (SIW'(i) > stage_idx_q)) begin
        next_found = 1'b1;
        next_idx   = SIW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_en_d  = stage_en_q;
    stage_idx_d = stage_idx_q;
    err_stage_d = err_stage_q;
    pass_cnt_d  = pass_cnt_q;
    succ_d      = succ_q;
    err_d       = err_q;
    if (abort && (state_q != ST_ERR)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            stage_en_d = stage_en;
            succ_d     = 1'b0;
            if (first_found) begin
              state_d     = ST_REQ;
              stage_idx_d = first_idx;
            end else begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_REQ: begin
          if (req_ready[stage_idx_q]) begin
            state_d = ST_WAIT;
          end else if (tmo_expired) begin
            state_d                  = ST_ERR;
            err_d                    = 1'b1;
            err_stage_d              = '0;
            err_stage_d[SIW-1:0]     = stage_idx_q;
            err_stage_d[ERR_REQ]     = 1'b1;
          end
        end
        ST_WAIT: begin
          if (res_valid[stage_idx_q]) begin
            state_d = ST_POST;
          end else if (tmo_expired) begin
            state_d              = ST_ERR;
            err_d                = 1'b1;
            err_stage_d          = '0;
            err_stage_d[SIW-1:0] = stage_idx_q;
          end
        end
        ST_POST: state_d = ST_ACK;
        ST_ACK: begin
          if (next_found) begin
            state_d     = ST_REQ;
            stage_idx_d = next_idx;
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          succ_d     = (check_a == check_b);
          pass_cnt_d = pass_cnt_q + PCW'(1);
          state_d    = ST_DONE;
        end
        ST_DONE: begin
          if (!loop_mode) begin
            state_d = ST_IDLE;
          end else if (first_q_found) begin
            state_d     = ST_REQ;
            stage_idx_d = first_q_idx;
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_ERR: begin
          if (err_clr) begin
            state_d     = ST_IDLE;
            err_d       = 1'b0;
            err_stage_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they leave a flop directly.
  always_comb begin
    req_valid_d = '0;
    res_ready_d = '0;
    if (state_d == ST_REQ) begin
      req_valid_d[stage_idx_d] = 1'b1;
    end
    if (state_d == ST_POST) begin
      res_ready_d[stage_idx_d] = 1'b1;
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      stage_en_q  <= '0;
      stage_idx_q <= '0;
      err_stage_q <= '0;
      pass_cnt_q  <= '0;
      succ_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= '0;
      res_ready_q <= '0;
    end else begin
      state_q     <= state_d;
      stage_en_q  <= stage_en_d;
      stage_idx_q <= stage_idx_d;
      err_stage_q <= err_stage_d;
      pass_cnt_q  <= pass_cnt_d;
      succ_q      <= succ_d;
      err_q       <= err_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      res_ready_q <= res_ready_d;
    end
  end

  // Every state change lands on a fresh phase, so any change restarts the watchdog.
  assign tmo_clear  = (state_d != state_q);
  assign tmo_enable = (state_q == ST_REQ) || (state_q == ST_WAIT);

  seq_timeout #(
    .TMO(TMO)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  assign req_valid = req_valid_q;
  assign res_ready = res_ready_q;
  assign post_stb  = res_ready_q;
  assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign done      = done_q;
  assign succ      = succ_q;
  assign err       = err_q;
  assign err_stage = err_stage_q;
  assign stage_idx = stage_idx_q;
  assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: stage models with programmable response delay,
// scoreboard queues for post strobes and completed passes.
module tb_stage_sequencer;

  localparam int NSTAGE = 3;
  localparam int W      = 128;
  localparam int TMO    = 16;
  localparam int PCW    = 16;
  localparam int SIW    = 2;

  localparam logic [W-1:0] KEY = 128'h1398_5a2c_d40f_77e1_0b96_c3a8_e25d_71e9;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0, abort = 1'b0, loop_mode = 1'b0, err_clr = 1'b0;
  logic [NSTAGE-1:0] stage_en = '0;
  logic [NSTAGE-1:0] req_ready = '1;
  logic [NSTAGE-1:0] req_busy, res_valid, req_valid, res_ready, post_stb;
  logic [W-1:0] check_a = '0, check_b = '0;
  logic busy, done, succ, err;
  logic [SIW:0] err_stage;
  logic [SIW-1:0] stage_idx;
  logic [PCW-1:0] pass_cnt;

  typedef struct {
    bit succ;
    int cnt;
    int cycle;
  } done_exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_seen = 0;
  bit saw_rv1 = 1'b0;
  int delay[NSTAGE];
  bit never[NSTAGE];
  logic [NSTAGE-1:0] pending;
  int wc[NSTAGE];
  int exp_post[$];
  done_exp_t exp_done[$];
  done_exp_t mon_d;
  int mon_e;
  int rel;

  stage_sequencer #(
    .NSTAGE(NSTAGE), .W(W), .TMO(TMO), .PCW(PCW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .loop_mode(loop_mode),
    .err_clr(err_clr), .stage_en(stage_en), .req_ready(req_ready), .req_busy(req_busy),
    .res_valid(res_valid), .req_valid(req_valid), .res_ready(res_ready), .post_stb(post_stb),
    .check_a(check_a), .check_b(check_b), .busy(busy), .done(done), .succ(succ), .err(err),
    .err_stage(err_stage), .stage_idx(stage_idx), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stage models: accept a request, then raise res_valid once delay[i] cycles have passed.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
      for (int i = 0; i < NSTAGE; i++) wc[i] <= 0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          pending[i] <= 1'b1;
          wc[i]      <= 0;
        end else if (res_ready[i]) begin
          pending[i] <= 1'b0;
        end else if (pending[i]) begin
          wc[i] <= wc[i] + 1;
        end
      end
    end
  end

  always_comb begin
    res_valid = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      res_valid[i] = pending[i] && !never[i] && (wc[i] >= delay[i]);
    end
  end

  assign req_busy = pending;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: pops expectations whenever the DUT strobes a stage or finishes a pass.
  always @(negedge clk) begin
    if (rstn) begin
      if (req_valid[1]) saw_rv1 = 1'b1;
      if (req_valid != '0) checkOutput("req_onehot", 128'($onehot(req_valid)), 1);
      if ((post_stb | res_ready) != '0) begin
        if (exp_post.size() == 0) begin
          checkOutput("post_unexpected", post_stb, 0);
        end else begin
          mon_e = exp_post.pop_front();
          checkOutput("post_stb", post_stb, 128'(1) << mon_e);
          checkOutput("res_ready", res_ready, 128'(1) << mon_e);
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done.size() == 0) begin
          checkOutput("done_unexpected", done, 0);
        end else begin
          mon_d = exp_done.pop_front();
          checkOutput("succ", succ, mon_d.succ);
          checkOutput("pass_cnt", pass_cnt, mon_d.cnt);
          checkOutput("done_cycle", cyc - t0, mon_d.cycle);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NSTAGE-1:0] en, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic lm);
    @(negedge clk);
    stage_en  = en;
    check_a   = a;
    check_b   = b;
    loop_mode = lm;
    start     = 1'b1;
    t0        = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while ((done_seen < target) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_seen < target) checkOutput("done_wait", done_seen, target);
  endtask

  task automatic waitErr(input int budget, output int when);
    int n = 0;
    while (!err && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    when = cyc - t0;
    if (!err) checkOutput("err_wait", err, 1);
  endtask

  task automatic clearErr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    #1;
    err_clr = 1'b0;
    checkOutput("err_cleared", err, 0);
    checkOutput("err_stage_cleared", err_stage, 0);
    checkOutput("busy_after_clr", busy, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NSTAGE; i++) begin
      delay[i] = 0;
      never[i] = 1'b0;
    end

    // Reset state
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_outputs",
                {req_valid, res_ready, post_stb, busy, done, succ, err, err_stage, stage_idx, pass_cnt}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic pass: all stages, immediate answers
    for (int s = 0; s < NSTAGE; s++) exp_post.push_back(s);
    exp_done.push_back('{1'b1, 1, 14});
    applyStimulus(3'b111, KEY, KEY, 1'b0);
    waitDone(1, 40);
    @(negedge clk);
    #1;
    checkOutput("done_pulse_width", done, 0);
    checkOutput("idle_after_pass", busy, 0);

    // Skip stage 1, slow stage 2, mismatching operands
    saw_rv1  = 1'b0;
    delay[2] = 10;
    exp_post.push_back(0);
    exp_post.push_back(2);
    exp_done.push_back('{1'b0, 2, 20});
    applyStimulus(3'b101, KEY, KEY ^ 128'd1, 1'b0);
    waitDone(2, 60);
    checkOutput("skip_no_req1", saw_rv1, 0);
    delay[2] = 0;

    // WAIT-phase timeout on stage 1
    never[1] = 1'b1;
    exp_post.push_back(0);
    applyStimulus(3'b111, KEY, KEY, 1'b0);
    waitErr(60, rel);
    checkOutput("wait_tmo_cycle", rel, 4 * 1 + 2 + TMO);
    checkOutput("wait_tmo_stage", err_stage, 3'b001);
    checkOutput("tmo_req_valid", req_valid, 0);
    checkOutput("tmo_res_ready", res_ready, 0);
    checkOutput("tmo_busy", busy, 0);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("err_holds", err, 1);
    checkOutput("err_ignores_start", req_valid, 0);
    clearErr();
    never[1] = 1'b0;

    // REQ-phase timeout on stage 0
    req_ready = 3'b110;
    applyStimulus(3'b111, KEY, KEY, 1'b0);
    waitErr(60, rel);
    checkOutput("req_tmo_cycle", rel, 1 + TMO);
    checkOutput("req_tmo_stage", err_stage, 3'b100);
    checkOutput("req_tmo_valid", req_valid, 0);
    clearErr();
    req_ready = '1;

    // Loop mode for three passes, then abort in WAIT of stage 2
    doReset();
    for (int p = 1; p <= 3; p++) begin
      for (int s = 0; s < NSTAGE; s++) exp_post.push_back(s);
      exp_done.push_back('{1'b1, p, 14 * p});
    end
    exp_post.push_back(0);
    exp_post.push_back(1);
    applyStimulus(3'b111, KEY, KEY, 1'b1);
    waitDone(5, 150);
    n = 0;
    while (!req_valid[2] && (n < 20)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("loop_reach_req2", req_valid[2], 1);
    @(negedge clk);
    #1;
    checkOutput("abort_in_wait_idx", stage_idx, 2);
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort     = 1'b0;
    loop_mode = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_req_valid", req_valid, 0);
    checkOutput("abort_res_ready", res_ready, 0);
    checkOutput("abort_pass_cnt", pass_cnt, 3);
    checkOutput("abort_succ", succ, 1);
    @(negedge clk);
    #1;
    checkOutput("abort_stays_idle", busy, 0);

    // Reset mid-REQ, then a fresh run
    applyStimulus(3'b111, KEY, KEY, 1'b0);
    #1;
    checkOutput("midreq_valid", req_valid, 3'b001);
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {req_valid, res_ready, post_stb, busy, done, succ, err, err_stage, stage_idx, pass_cnt}, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int s = 0; s < NSTAGE; s++) exp_post.push_back(s);
    exp_done.push_back('{1'b1, 1, 14});
    applyStimulus(3'b111, KEY, KEY, 1'b0);
    waitDone(6, 40);

    repeat (2) @(negedge clk);
    checkOutput("post_queue_empty", exp_post.size(), 0);
    checkOutput("done_queue_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
